// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the cache block fill controller.
package mem_ctrl_pkg;

    localparam int          MEM_LAT_DEF = 4;
    localparam int          WORDS_DEF   = 8;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_e;

    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & BLOCK_MASK;
    endfunction

    function automatic owner_e other_owner(input owner_e owner);
        return (owner == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/miss_arbiter.sv
// Two-way round-robin grant between I- and D-cache miss requests.
module miss_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic   i_en,
    input  logic   i_i_req,
    input  logic   i_d_req,
    input  owner_e i_favour,
    output logic   o_grant,
    output owner_e o_owner
);

    // Grant selection; a tie goes to the favoured requester.
    always_comb begin
        o_grant = 1'b0;
        o_owner = OWN_D;
        if (i_en) begin
            case ({i_d_req, i_i_req})
                2'b11: begin
                    o_grant = 1'b1;
                    o_owner = i_favour;
                end
                2'b10: begin
                    o_grant = 1'b1;
                    o_owner = OWN_D;
                end
                2'b01: begin
                    o_grant = 1'b1;
                    o_owner = OWN_I;
                end
                default: begin
                    o_grant = 1'b0;
                    o_owner = OWN_D;
                end
            endcase
        end else begin
            o_grant = 1'b0;
        end
    end

endmodule

// File: rtl/mem_fill_ctrl.sv
// Shared main-memory port: D-cache write-through stores and I/D block fills.
module mem_fill_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int WORDS   = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic        d_miss,
    input  logic [15:0] i_miss_addr,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        d_wr_ack,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_idx,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        busy
);

    localparam int              CNT_W    = $clog2(WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS);

    // The block mask and 3-bit word index fix the geometry at 8 words.
    if (WORDS != 8 || MEM_LAT < 1) begin : g_param_check
        $error("mem_fill_ctrl: unsupported WORDS/MEM_LAT");
    end

    fill_state_e      r_state;
    fill_state_e      w_next_state;
    logic [15:0]      r_base;
    owner_e           r_owner;
    owner_e           r_favour;
    logic [CNT_W-1:0] r_icnt;
    logic [CNT_W-1:0] r_rcnt;
    logic             w_arb_en;
    logic             w_grant;
    owner_e           w_grant_owner;
    logic [15:0]      w_grant_addr;
    logic             w_rx;
    logic             w_rx_last;

    assign w_arb_en     = (r_state == ST_IDLE) && !d_wr_req;
    assign w_grant_addr = (w_grant_owner == OWN_I) ? i_miss_addr : d_miss_addr;
    assign w_rx_last    = w_rx && (r_rcnt == LAST_IDX);
    assign busy         = (r_state != ST_IDLE);

    miss_arbiter u_arb (
        .i_en     (w_arb_en),
        .i_i_req  (i_miss),
        .i_d_req  (d_miss),
        .i_favour (r_favour),
        .o_grant  (w_grant),
        .o_owner  (w_grant_owner)
    );

    // Next-state and memory-port/done-pulse decode.
    always_comb begin
        w_next_state = r_state;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;
        d_wr_ack     = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // rst_n gate keeps the store path quiet while reset is held.
                if (rst_n && d_wr_req) begin
                    mem_en       = 1'b1;
                    mem_wr       = 1'b1;
                    mem_addr     = d_wr_addr;
                    mem_wdata    = d_wr_data;
                    d_wr_ack     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_grant) begin
                    w_next_state = ST_FILL;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FILL: begin
                mem_en   = 1'b1;
                mem_addr = r_base + 16'({r_icnt, 1'b0});
                if (r_icnt == LAST_IDX) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (w_rx_last || (r_rcnt == FULL_CNT)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (r_owner == OWN_I) begin
                    i_fill_done = 1'b1;
                end else begin
                    d_fill_done = 1'b1;
                end
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Receive path: forward returned words to the owning cache's data array.
    always_comb begin
        w_rx      = 1'b0;
        fill_data = 16'h0000;
        fill_idx  = 3'd0;
        i_fill_we = 1'b0;
        d_fill_we = 1'b0;
        if ((r_state == ST_FILL || r_state == ST_DRAIN) && mem_rvalid && (r_rcnt < FULL_CNT)) begin
            w_rx      = 1'b1;
            fill_data = mem_rdata;
            fill_idx  = r_rcnt[2:0];
            if (r_owner == OWN_I) begin
                i_fill_we = 1'b1;
            end else begin
                d_fill_we = 1'b1;
            end
        end else begin
            w_rx = 1'b0;
        end
    end

    // State, block base, owner, counters and round-robin favour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_base   <= 16'h0000;
            r_owner  <= OWN_D;
            r_favour <= OWN_D;
            r_icnt   <= {CNT_W{1'b0}};
            r_rcnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_base  <= block_base(w_grant_addr);
                r_owner <= w_grant_owner;
                r_icnt  <= {CNT_W{1'b0}};
                r_rcnt  <= {CNT_W{1'b0}};
            end else begin
                if (r_state == ST_FILL) begin
                    r_icnt <= r_icnt + CNT_W'(1);
                end else begin
                    r_icnt <= r_icnt;
                end
                if (w_rx) begin
                    r_rcnt <= r_rcnt + CNT_W'(1);
                end else begin
                    r_rcnt <= r_rcnt;
                end
            end
            // After a fill the other cache wins the next tie.
            if (r_state == ST_DONE) begin
                r_favour <= other_owner(r_owner);
            end else begin
                r_favour <= r_favour;
            end
        end
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Scoreboard bench for mem_fill_ctrl with a fixed-latency memory model.
module tb_mem_fill_ctrl;

    localparam int MEM_LAT = 4;
    localparam int WORDS   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_miss_addr = 16'h0, d_miss_addr = 16'h0;
    logic [15:0] d_wr_addr = 16'h0, d_wr_data = 16'h0;
    logic        d_wr_ack, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;

    always #5 clk = ~clk;

    mem_fill_ctrl #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .d_miss(d_miss),
        .i_miss_addr(i_miss_addr), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .d_wr_ack(d_wr_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct { int t; logic [15:0] a; } pend_t;
    pend_t       pipe[$];
    logic [15:0] q_rd[$];
    logic [31:0] q_wr[$];
    logic [19:0] q_fill[$];
    bit          q_done[$];

    int rd_first = -1, fill_first = -1, ack_cyc = -1;
    int done_cyc_d = -1, done_cyc_i = -1;
    bit seen_d = 1'b0, seen_i = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: each read returns MEM_LAT cycles after issue, in order.
    always @(posedge clk) begin
        #1;
        if (pipe.size() > 0 && pipe[0].t == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_val(pipe[0].a);
            void'(pipe.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'h0;
        end
    end

    // Output monitor: compare every DUT event against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en && !mem_wr) begin
                if (rd_first < 0) rd_first = cyc;
                check_eq("rd_pending", 64'(q_rd.size() > 0), 64'd1);
                if (q_rd.size() > 0) check_eq("rd_addr", 64'(mem_addr), 64'(q_rd.pop_front()));
                pipe.push_back('{cyc + MEM_LAT, mem_addr});
            end
            if (d_wr_ack || (mem_en && mem_wr)) begin
                ack_cyc = cyc;
                check_eq("wr_ack_strobe", {61'd0, d_wr_ack, mem_en, mem_wr}, 64'd7);
                check_eq("wr_pending", 64'(q_wr.size() > 0), 64'd1);
                if (q_wr.size() > 0) check_eq("wr_addr_data", {32'd0, mem_addr, mem_wdata}, 64'(q_wr.pop_front()));
            end
            if (i_fill_we || d_fill_we) begin
                if (fill_first < 0) fill_first = cyc;
                check_eq("we_onehot", 64'(i_fill_we & d_fill_we), 64'd0);
                check_eq("fill_pending", 64'(q_fill.size() > 0), 64'd1);
                if (q_fill.size() > 0) check_eq("fill_word", {44'd0, i_fill_we, fill_idx, fill_data}, 64'(q_fill.pop_front()));
            end
            if (i_fill_done || d_fill_done) begin
                if (d_fill_done) begin seen_d = 1'b1; done_cyc_d = cyc; end
                if (i_fill_done) begin seen_i = 1'b1; done_cyc_i = cyc; end
                check_eq("done_onehot", 64'(i_fill_done & d_fill_done), 64'd0);
                check_eq("done_pending", 64'(q_done.size() > 0), 64'd1);
                if (q_done.size() > 0) check_eq("done_owner", 64'(i_fill_done), 64'(q_done.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fill(input bit own, input logic [15:0] addr);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < WORDS; k++) begin
            q_rd.push_back(base + 16'(2 * k));
            q_fill.push_back({own, 3'(k), mem_val(base + 16'(2 * k))});
        end
        q_done.push_back(own);
        if (own) seen_i = 1'b0; else seen_d = 1'b0;
        rd_first   = -1;
        fill_first = -1;
    endtask

    task automatic wait_done(input bit own, input int bound);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < bound && !hit; n++) begin
            step();
            hit = own ? seen_i : seen_d;
        end
        check_eq(own ? "i_done_seen" : "d_done_seen", 64'(hit), 64'd1);
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq(tag, {busy, mem_en, mem_wr, d_wr_ack, i_fill_we, d_fill_we, i_fill_done,
                       d_fill_done, fill_idx, mem_addr, mem_wdata, fill_data}, 64'd0);
    endtask

    int t0;

    initial begin
        // Reset, with requests and a read return forced in to prove the gating.
        repeat (2) step();
        d_wr_req = 1'b1; d_wr_addr = 16'h1111; d_wr_data = 16'h2222; d_miss = 1'b1;
        #1;
        check_outs_zero("reset_outputs");
        d_wr_req = 1'b0; d_miss = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Single D miss: latency profile and block-aligned addresses.
        t0 = cyc;
        expect_fill(1'b0, 16'h1236);
        d_miss_addr = 16'h1236; d_miss = 1'b1;
        step();
        check_eq("busy_in_fill", 64'(busy), 64'd1);
        wait_done(1'b0, 40);
        d_miss = 1'b0;
        check_eq("d_first_read_cyc", 64'(rd_first - t0), 64'd1);
        check_eq("d_first_fill_cyc", 64'(fill_first - t0), 64'd5);
        check_eq("d_done_cyc", 64'(done_cyc_d - t0), 64'd13);
        check_eq("busy_back_idle", 64'(busy), 64'd0);

        // Both misses from reset: D first, I follows 14 cycles later.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        expect_fill(1'b0, 16'h3000);
        expect_fill(1'b1, 16'h2008);
        i_miss_addr = 16'h2008; d_miss_addr = 16'h3000; i_miss = 1'b1; d_miss = 1'b1;
        wait_done(1'b0, 40);
        d_miss = 1'b0;
        wait_done(1'b1, 40);
        i_miss = 1'b0;
        check_eq("i_after_d_gap", 64'(done_cyc_i - done_cyc_d), 64'd14);

        // Store beats a concurrent I miss; the fill is granted next cycle.
        t0 = cyc;
        ack_cyc = -1;
        q_wr.push_back({16'h4000, 16'hBEEF});
        expect_fill(1'b1, 16'h5552);
        d_wr_addr = 16'h4000; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
        i_miss_addr = 16'h5552; i_miss = 1'b1;
        step();
        d_wr_req = 1'b0;
        wait_done(1'b1, 40);
        i_miss = 1'b0;
        check_eq("store_ack_cyc", 64'(ack_cyc - t0), 64'd0);
        check_eq("i_first_read_cyc", 64'(rd_first - t0), 64'd2);
        check_eq("i_done_cyc", 64'(done_cyc_i - t0), 64'd14);

        // Store raised mid-fill is held off until the controller is idle.
        expect_fill(1'b0, 16'h7010);
        d_miss_addr = 16'h7010; d_miss = 1'b1;
        repeat (3) step();
        ack_cyc = -1;
        q_wr.push_back({16'h7100, 16'h1234});
        d_wr_addr = 16'h7100; d_wr_data = 16'h1234; d_wr_req = 1'b1;
        wait_done(1'b0, 40);
        d_miss = 1'b0;
        check_eq("no_ack_while_busy", 64'(ack_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        d_wr_req = 1'b0;
        check_eq("held_store_cyc", 64'(ack_cyc - done_cyc_d), 64'd1);

        // Reset mid-fill: abort, no done, stray returns after release ignored.
        t0 = cyc;
        for (int k = 0; k < 5; k++) q_rd.push_back(16'h9AB0 + 16'(2 * k));
        q_fill.push_back({1'b1, 3'd0, mem_val(16'h9AB0)});
        i_miss_addr = 16'h9ABC; i_miss = 1'b1;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        check_outs_zero("reset_midfill_outputs");
        i_miss = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check_eq("abort_rd_left", 64'(q_rd.size()), 64'd0);
        check_eq("abort_fill_left", 64'(q_fill.size()), 64'd0);
        check_eq("abort_no_done", 64'(q_done.size()), 64'd0);

        // Fresh miss at the top of the address space completes normally.
        t0 = cyc;
        expect_fill(1'b0, 16'hFFFE);
        d_miss_addr = 16'hFFFE; d_miss = 1'b1;
        wait_done(1'b0, 40);
        d_miss = 1'b0;
        check_eq("top_done_cyc", 64'(done_cyc_d - t0), 64'd13);

        repeat (3) step();
        check_eq("sb_rd_empty", 64'(q_rd.size()), 64'd0);
        check_eq("sb_fill_empty", 64'(q_fill.size()), 64'd0);
        check_eq("sb_wr_empty", 64'(q_wr.size()), 64'd0);
        check_eq("sb_done_empty", 64'(q_done.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 4: main-memory read latency in cycles from issue to data.
REQ-002 Parameter WORDS, default 8: 16-bit words per cache block (16 B block).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_miss / d_miss  in  1 each  I-/D-cache miss request, level, held until matching done.
REQ-006 i_miss_addr / d_miss_addr  in  16 each  missing byte address.
REQ-007 d_wr_req  in  1  D-cache write-through store request, level.
REQ-008 d_wr_addr / d_wr_data  in  16 each  store address and data.
REQ-009 d_wr_ack  out  1  one-cycle pulse: store issued to memory this cycle.
REQ-010 mem_en / mem_wr  out  1 each  memory request strobe; 1 = write, 0 = read.
REQ-011 mem_addr / mem_wdata  out  16 each  memory address and write data.
REQ-012 mem_rvalid / mem_rdata  in  1 / 16  read data return, pipelined, in issue order.
REQ-013 fill_data / fill_idx  out  16 / 3  word to write into cache data array and its word index.
REQ-014 i_fill_we / d_fill_we  out  1 each  data-array write enable for granted cache.
REQ-015 i_fill_done / d_fill_done  out  1 each  one-cycle pulse: block complete, write tag/valid.
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 FSM states IDLE, FILL, DRAIN, DONE; transitions only on clk edge.
REQ-018 IDLE arbitration priority: d_wr_req highest; then misses round-robin by last_grant bit (after an I fill D wins a tie, and vice versa; reset value favours D).
REQ-019 Store in IDLE: same cycle mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1; state stays IDLE; misses wait one cycle.
REQ-020 Miss grant in IDLE: latch base = addr & 16'hFFF0 and owner; next state FILL; no memory access in the grant cycle.
REQ-021 FILL: issue one read per cycle, mem_en=1, mem_wr=0, mem_addr = base + 2*k for k = 0..WORDS-1; after word WORDS-1 go to DRAIN.
REQ-022 Receive path, active in FILL and DRAIN: each mem_rvalid asserts owner's fill_we combinationally that cycle with fill_data=mem_rdata and fill_idx = receive count; receive count then increments.
REQ-023 DRAIN to DONE on the edge ending the cycle of the WORDS-th return; DONE lasts one cycle, pulses owner's fill_done, toggles last_grant, returns to IDLE.
REQ-024 Latency (MEM_LAT=4, WORDS=8): request seen cycle 0, issues cycles 1..8, data cycles 5..12, done pulse cycle 13.
REQ-025 d_wr_req during FILL/DRAIN/DONE is held off (no ack) until IDLE.
REQ-026 Miss deasserted mid-fill: fill still completes, done still pulses.
REQ-027 mem_rvalid in IDLE, or beyond WORDS returns, is ignored; no fill_we.
REQ-028 Address arithmetic modulo 2^16; base+14 never crosses the block.

Reset
REQ-029 rst_n low, asynchronous: state=IDLE, counters=0, last_grant=D, all outputs 0 including busy, fill_idx, mem_addr.
REQ-030 Reset mid-fill aborts; no done pulse; late returns after release are ignored per REQ-027.

Structure
REQ-031 Package mem_ctrl_pkg holds the FSM state enum, WORDS, MEM_LAT defaults and the block mask 16'hFFF0.
REQ-032 The two-way round-robin grant logic is sub-module miss_arbiter; everything else stays in mem_fill_ctrl.

Verification
REQ-033 d_miss, addr 16'h1236, cycle 0 -> reads 16'h1230..16'h123E cycles 1..8; d_fill_we with fill_idx 0..7 cycles 5..12; d_fill_done cycle 13.
REQ-034 i_miss and d_miss both raised from reset -> D filled first, then I; i_fill_done 14 cycles after d_fill_done.
REQ-035 d_wr_req (16'h4000, 16'hBEEF) with i_miss in IDLE -> write issued and acked that cycle; I fill grant the next cycle.
REQ-036 d_wr_req raised at FILL cycle 3 -> no ack until IDLE; write issued the cycle after done.
REQ-037 rst_n low at cycle 6 of a fill -> all outputs 0 immediately; stray mem_rvalid after release gives no fill_we; a new miss completes normally.
